alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
- Parametrised ALU control unit for the MIPS core.
- Decodes `ctrl_op` and `funct` into an ALU control code and a `jump_reg` flag, as the combinational decoder does today.
- Adds a sequencer for iterative multiply/divide instructions.
- Issues start pulses to the multiply/divide unit, stalls PC/register writeback until the result is ready, then pulses the HI/LO write enable.
- Sits between the main control unit, the ALU, the mul/div unit and the PC-enable logic.

Parameters:
- `CTRL_W`, 4: width of `alu_ctrl`. Legal range is ≥4; codes are zero-extended.
- `MUL_CYCLES`, 4: busy cycles of the multiplier after start. Legal range is 1..255.
- `DIV_CYCLES`, 32: busy cycles of the divider after start. Legal range is 1..255.
- `CNT_W`, 8: countdown counter width. Must satisfy `CNT_W` ≥ clog2(max(`MUL_CYCLES`, `DIV_CYCLES`)+1).

Ports:
- `clk`, in, 1: core clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `instr_valid`, in, 1: the current instruction's decode inputs are valid.
- `ctrl_op`, in, 3: ALU op class from the main control unit.
- `funct`, in, 6: R-type function field.
- `alu_ctrl`, out, `CTRL_W`: ALU operation code.
- `jump_reg`, out, 1: the current instruction is `jr`.
- `hilo_sel`, out, 2: writeback source. 01 = HI (`mfhi`), 10 = LO (`mflo`), 00 = ALU.
- `md_start`, out, 1: one-cycle start pulse to the mul/div unit.
- `md_op`, out, 1: operation for the mul/div unit. 0 = multiply, 1 = divide. Valid while `md_start` is high.
- `hilo_we`, out, 1: one-cycle HI/LO write strobe.
- `stall`, out, 1: hold PC and suppress register-file write.
- `illegal`, out, 1: unsupported R-type funct.

Behaviour:
- Clocking and reset:
  - One clock, `clk`. Reset `rst_n` is asynchronous and active-low.
  - Reset values: state=IDLE, counter=0, `md_start`=0, `md_op`=0, `hilo_we`=0. `stall`=0 while in reset.
- Decode is combinational, zero latency, and independent of FSM state.
- Non-R-type `ctrl_op` codes:
  - 000 → add, code 0010.
  - 001 → sub, 0110.
  - 011 → and, 0000.
  - 100 → or, 0001.
  - 101 → slt, 0111.
  - Any other value → all-ones.
- R-type (`ctrl_op`=010) funct codes:
  - 100000 add → 0010.
  - 100010 sub → 0110.
  - 100100 and → 0000.
  - 100101 or → 0001.
  - 100111 nor → 0100.
  - 000000 sll → 0101.
  - 000010 srl → 1000.
  - 101010 slt → 0111.
  - 101001 sltu → 1001.
  - 001000 jr → all-ones with `jump_reg`=1.
  - 011000 mult → all-ones, md instruction.
  - 011010 div → all-ones, md instruction.
  - 010000 mfhi → all-ones, `hilo_sel`=01.
  - 010010 mflo → all-ones, `hilo_sel`=10.
  - Any other funct → all-ones, `illegal`=1.
- `illegal` and `jump_reg` are gated by `instr_valid`.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - If `instr_valid` and md instruction: `stall`=1 combinationally.
  - Next state is MUL or DIV; counter loads `MUL_CYCLES`-1 or `DIV_CYCLES`-1.
  - `md_start`=1 and `md_op` are registered, so they are high in the first MUL/DIV cycle.
- MUL/DIV:
  - `stall`=1.
  - Counter decrements each cycle. At counter==0, go to DONE.
  - Inputs are ignored, including `instr_valid` deasserting.
- DONE:
  - `stall`=0 and `hilo_we`=1 for exactly one cycle. The instruction retires at the end of this cycle.
  - Next state is IDLE. A md instruction still present in DONE must not re-trigger.
- Timing: an md instruction occupies N+2 cycles (N = `MUL_CYCLES` or `DIV_CYCLES`), with `stall` high for N+1 of them.
- `mfhi`/`mflo` are accepted only in IDLE. They cannot coincide with a busy unit because the core is stalled.
- Reset mid-operation: immediate return to IDLE. No `hilo_we` is issued.
- Counter never wraps. It is loaded only in IDLE.

Optional Feature:
- Macro: `ALU_CTRL_DIV_EN`.
- Defined: div (funct 011010) is supported; DIV state present; `DIV_CYCLES` used.
- Undefined:
  - Funct 011010 decodes as illegal and never stalls.
  - DIV state and `md_op`=1 are never produced; `md_op` is tied 0.
  - `DIV_CYCLES` is unused.

Decomposition:
- Package `alu_ctrl_pkg` holds:
  - ALU code localparams (ADD, SUB, AND, OR, NOR, SLL, SRL, SLT, SLTU, NOP).
  - funct and `ctrl_op` constants.
  - FSM state encoding.
- One natural sub-module: `alu_ctrl_dec`, the pure combinational decode. It outputs `alu_ctrl`, `jump_reg`, `hilo_sel`, `illegal`, `is_mult`, `is_div`.
- FSM and counter live in the top level.

Test Plan:
- Decode sweep: all non-R `ctrl_op` codes and all listed functs with `instr_valid`=1 → codes match the tables. funct 111111 → `illegal`=1, `alu_ctrl`=1111.
- mult with `MUL_CYCLES`=4 → `stall` high for cycles 0–4, `md_start` high in cycle 1 with `md_op`=0, `hilo_we` high in cycle 5 with `stall`=0, IDLE in cycle 6.
- div with `ALU_CTRL_DIV_EN` defined and `DIV_CYCLES`=32 → `stall` high for 33 cycles, `md_op`=1 on start, single `hilo_we`. Without the macro: `illegal`=1, `stall`=0.
- Assert `rst_n` low during cycle 2 of a mult → outputs reset immediately, no `hilo_we`. After release, a fresh add decodes to 0010 with no stall.
- Back-to-back mult then mflo → the mult completes, then mflo shows `hilo_sel`=10 with `stall`=0. `instr_valid` toggled low mid-mult does not shorten the stall.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared ALU codes, opcode/funct constants and FSM encoding
// for the ALU control sequencer.
package alu_ctrl_pkg;

   // ALU operation codes (4-bit, zero-extended to CTRL_W by the decoder)
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_NOR  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1001;
   localparam logic [3:0] ALU_NOP  = 4'b1111;

   // ALU op classes from the main control unit
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_R   = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;

   // R-type funct fields
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLTU = 6'b101001;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_MULT = 6'b011000;
   localparam logic [5:0] FN_DIV  = 6'b011010;
   localparam logic [5:0] FN_MFHI = 6'b010000;
   localparam logic [5:0] FN_MFLO = 6'b010010;

   // Writeback source select
   localparam logic [1:0] HS_ALU = 2'b00;
   localparam logic [1:0] HS_HI  = 2'b01;
   localparam logic [1:0] HS_LO  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: pure combinational decode of ctrl_op/funct.
// Build macro ALU_CTRL_DIV_EN enables div decode; without it div is illegal.
module alu_ctrl_dec
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned CTRL_W = 4
) (
   input  logic              instr_valid,
   input  logic [2:0]        ctrl_op,
   input  logic [5:0]        funct,
   output logic [CTRL_W-1:0] alu_ctrl,
   output logic              jump_reg,
   output logic [1:0]        hilo_sel,
   output logic              illegal,
   output logic              is_mult,
   output logic              is_div
);

   logic [3:0] code;
   logic       jr_raw;
   logic       ill_raw;

   // Table decode; everything not matched falls back to NOP
   always_comb begin
      code     = ALU_NOP;
      jr_raw   = 1'b0;
      ill_raw  = 1'b0;
      hilo_sel = HS_ALU;
      is_mult  = 1'b0;
      is_div   = 1'b0;
      case (ctrl_op)
         OP_ADD: code = ALU_ADD;
         OP_SUB: code = ALU_SUB;
         OP_AND: code = ALU_AND;
         OP_OR:  code = ALU_OR;
         OP_SLT: code = ALU_SLT;
         OP_R: begin
            case (funct)
               FN_ADD:  code = ALU_ADD;
               FN_SUB:  code = ALU_SUB;
               FN_AND:  code = ALU_AND;
               FN_OR:   code = ALU_OR;
               FN_NOR:  code = ALU_NOR;
               FN_SLL:  code = ALU_SLL;
               FN_SRL:  code = ALU_SRL;
               FN_SLT:  code = ALU_SLT;
               FN_SLTU: code = ALU_SLTU;
               FN_JR:   jr_raw = 1'b1;
               FN_MULT: is_mult = 1'b1;
`ifdef ALU_CTRL_DIV_EN
               FN_DIV:  is_div = 1'b1;
`else
               FN_DIV:  ill_raw = 1'b1;
`endif
               FN_MFHI: hilo_sel = HS_HI;
               FN_MFLO: hilo_sel = HS_LO;
               default: ill_raw = 1'b1;
            endcase
         end
         default: code = ALU_NOP;
      endcase
   end

   // NOP is all-ones at full width; real codes are zero-extended
   assign alu_ctrl = (code == ALU_NOP) ? {CTRL_W{1'b1}} : CTRL_W'(code);
   assign jump_reg = jr_raw & instr_valid;
   assign illegal  = ill_raw & instr_valid;

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: ALU control decode plus mul/div sequencer.
// An md instruction stalls for N+1 cycles, then pulses hilo_we for one cycle.
// Build macro ALU_CTRL_DIV_EN enables the divide path (DIV state, md_op=1).
module alu_ctrl_seq
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned CTRL_W     = 4,
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_CYCLES = 32,
   parameter int unsigned CNT_W      = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   input  logic [2:0]        ctrl_op,
   input  logic [5:0]        funct,
   output logic [CTRL_W-1:0] alu_ctrl,
   output logic              jump_reg,
   output logic [1:0]        hilo_sel,
   output logic              md_start,
   output logic              md_op,
   output logic              hilo_we,
   output logic              stall,
   output logic              illegal
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             md_start_d, md_op_d;
   logic             stall_c;
   logic             is_mult, is_div;
   logic             go_mul, go_div;

   alu_ctrl_dec #(.CTRL_W(CTRL_W)) u_dec (
      .instr_valid (instr_valid),
      .ctrl_op     (ctrl_op),
      .funct       (funct),
      .alu_ctrl    (alu_ctrl),
      .jump_reg    (jump_reg),
      .hilo_sel    (hilo_sel),
      .illegal     (illegal),
      .is_mult     (is_mult),
      .is_div      (is_div)
   );

   // is_div is never raised by the decoder when the divide path is disabled
   assign go_mul = instr_valid & is_mult;
   assign go_div = instr_valid & is_div;

   // State, countdown and registered start/op to the mul/div unit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         md_start <= 1'b0;
         md_op    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         md_start <= md_start_d;
         md_op    <= md_op_d;
      end
   end

   // Next state, counter and strobes; inputs are ignored while busy
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      md_start_d = 1'b0;
      md_op_d    = md_op;
      stall_c    = 1'b0;
      hilo_we    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (go_mul || go_div) begin
               stall_c    = 1'b1;
               md_start_d = 1'b1;
               md_op_d    = go_div;
               state_d    = go_div ? ST_DIV : ST_MUL;
               cnt_d      = go_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
            end
         end
         ST_MUL, ST_DIV: begin
            stall_c = 1'b1;
            if (cnt_q == '0) state_d = ST_DONE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_DONE: begin
            // instruction retires here; go straight back so it cannot re-trigger
            hilo_we = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Decode inputs may look like an md op during reset; never stall then
   assign stall = stall_c & rst_n;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed checks of decode tables, mult/div sequencing,
// reset mid-operation and back-to-back mult/mflo.
module tb_alu_ctrl_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       instr_valid;
   logic [2:0] ctrl_op;
   logic [5:0] funct;
   logic [3:0] alu_ctrl;
   logic       jump_reg;
   logic [1:0] hilo_sel;
   logic       md_start, md_op, hilo_we, stall, illegal;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_ctrl_seq #(.CTRL_W(4), .MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .ctrl_op     (ctrl_op),
      .funct       (funct),
      .alu_ctrl    (alu_ctrl),
      .jump_reg    (jump_reg),
      .hilo_sel    (hilo_sel),
      .md_start    (md_start),
      .md_op       (md_op),
      .hilo_we     (hilo_we),
      .stall       (stall),
      .illegal     (illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One decode step in IDLE: apply inputs at the falling edge and check
   task automatic dec(input string tag, input logic [2:0] op, input logic [5:0] fn,
                      input logic [3:0] code, input logic jr, input logic [1:0] hs,
                      input logic ill);
      @(negedge clk);
      instr_valid = 1'b1; ctrl_op = op; funct = fn;
      #1;
      chk({tag, " alu"}, 32'(alu_ctrl), 32'(code));
      chk({tag, " jr"}, 32'(jump_reg), 32'(jr));
      chk({tag, " hs"}, 32'(hilo_sel), 32'(hs));
      chk({tag, " ill"}, 32'(illegal), 32'(ill));
      chk({tag, " stall"}, 32'(stall), 0);
   endtask

   initial begin
      int hw_cyc, st_cnt, hw_cnt;

      // Reset with an md instruction on the inputs: everything quiet
      rst_n = 1'b0; instr_valid = 1'b1; ctrl_op = 3'b010; funct = 6'b011000;
      #12;
      chk("rst stall", 32'(stall), 0);
      chk("rst md_start", 32'(md_start), 0);
      chk("rst md_op", 32'(md_op), 0);
      chk("rst hilo_we", 32'(hilo_we), 0);
      @(negedge clk); instr_valid = 1'b0; rst_n = 1'b1;
      @(negedge clk); #1;
      chk("post rst stall", 32'(stall), 0);

      // Non-R op classes
      dec("op000", 3'b000, 6'b0, 4'b0010, 0, 2'b00, 0);
      dec("op001", 3'b001, 6'b0, 4'b0110, 0, 2'b00, 0);
      dec("op011", 3'b011, 6'b0, 4'b0000, 0, 2'b00, 0);
      dec("op100", 3'b100, 6'b0, 4'b0001, 0, 2'b00, 0);
      dec("op101", 3'b101, 6'b0, 4'b0111, 0, 2'b00, 0);
      dec("op110", 3'b110, 6'b0, 4'b1111, 0, 2'b00, 0);
      dec("op111", 3'b111, 6'b0, 4'b1111, 0, 2'b00, 0);
      // R-type functs (md ops covered by the sequencer steps)
      dec("add",  3'b010, 6'b100000, 4'b0010, 0, 2'b00, 0);
      dec("sub",  3'b010, 6'b100010, 4'b0110, 0, 2'b00, 0);
      dec("and",  3'b010, 6'b100100, 4'b0000, 0, 2'b00, 0);
      dec("or",   3'b010, 6'b100101, 4'b0001, 0, 2'b00, 0);
      dec("nor",  3'b010, 6'b100111, 4'b0100, 0, 2'b00, 0);
      dec("sll",  3'b010, 6'b000000, 4'b0101, 0, 2'b00, 0);
      dec("srl",  3'b010, 6'b000010, 4'b1000, 0, 2'b00, 0);
      dec("slt",  3'b010, 6'b101010, 4'b0111, 0, 2'b00, 0);
      dec("sltu", 3'b010, 6'b101001, 4'b1001, 0, 2'b00, 0);
      dec("jr",   3'b010, 6'b001000, 4'b1111, 1, 2'b00, 0);
      dec("mfhi", 3'b010, 6'b010000, 4'b1111, 0, 2'b01, 0);
      dec("mflo", 3'b010, 6'b010010, 4'b1111, 0, 2'b10, 0);
      dec("f3f",  3'b010, 6'b111111, 4'b1111, 0, 2'b00, 1);

      // instr_valid gates illegal and jump_reg
      @(negedge clk); instr_valid = 1'b0; funct = 6'b111111; #1;
      chk("gate ill", 32'(illegal), 0);
      funct = 6'b001000; #1;
      chk("gate jr", 32'(jump_reg), 0);

      // mult: stall cycles 0..4, start in cycle 1, hilo_we in 5, idle in 6
      @(negedge clk); instr_valid = 1'b1; ctrl_op = 3'b010; funct = 6'b011000; #1;
      chk("mul c0 stall", 32'(stall), 1);
      chk("mul c0 start", 32'(md_start), 0);
      chk("mul c0 alu", 32'(alu_ctrl), 32'hf);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk); #1;
         chk($sformatf("mul c%0d stall", c), 32'(stall), 1);
         chk($sformatf("mul c%0d start", c), 32'(md_start), (c == 1) ? 1 : 0);
         chk($sformatf("mul c%0d hilo_we", c), 32'(hilo_we), 0);
         if (c == 1) chk("mul c1 md_op", 32'(md_op), 0);
      end
      @(negedge clk); #1;
      chk("mul c5 hilo_we", 32'(hilo_we), 1);
      chk("mul c5 stall", 32'(stall), 0);
      @(negedge clk); instr_valid = 1'b0; #1;
      chk("mul c6 hilo_we", 32'(hilo_we), 0);
      chk("mul c6 stall", 32'(stall), 0);
      chk("mul c6 start", 32'(md_start), 0);

`ifdef ALU_CTRL_DIV_EN
      // div: 33 stall cycles, md_op=1 on start, exactly one hilo_we
      @(negedge clk); instr_valid = 1'b1; funct = 6'b011010; #1;
      chk("div ill", 32'(illegal), 0);
      st_cnt = 0; hw_cnt = 0;
      for (int c = 0; c <= 35; c++) begin
         if (c > 0) begin @(negedge clk); #1; end
         if (c == 34) begin instr_valid = 1'b0; #1; end
         if (c == 1) begin
            chk("div start", 32'(md_start), 1);
            chk("div md_op", 32'(md_op), 1);
         end
         if (c == 33) chk("div c33 hilo_we", 32'(hilo_we), 1);
         st_cnt += int'(stall);
         hw_cnt += int'(hilo_we);
      end
      chk("div stall cnt", st_cnt, 33);
      chk("div hilo cnt", hw_cnt, 1);
`else
      // div disabled: illegal, no stall, no start
      @(negedge clk); instr_valid = 1'b1; funct = 6'b011010; #1;
      chk("div ill", 32'(illegal), 1);
      chk("div stall", 32'(stall), 0);
      chk("div alu", 32'(alu_ctrl), 32'hf);
      @(negedge clk); #1;
      chk("div next start", 32'(md_start), 0);
      chk("div next stall", 32'(stall), 0);
      chk("div next md_op", 32'(md_op), 0);
      @(negedge clk); instr_valid = 1'b0;
`endif

      // Reset during cycle 2 of a mult: outputs drop at once, no hilo_we later
      @(negedge clk); instr_valid = 1'b1; funct = 6'b011000;
      @(negedge clk);
      @(negedge clk); #1;
      chk("rmul c2 stall", 32'(stall), 1);
      rst_n = 1'b0; #1;
      chk("rmul rst stall", 32'(stall), 0);
      chk("rmul rst start", 32'(md_start), 0);
      chk("rmul rst hilo_we", 32'(hilo_we), 0);
      @(negedge clk); instr_valid = 1'b0; rst_n = 1'b1;
      hw_cnt = 0; st_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk); #1;
         hw_cnt += int'(hilo_we);
         st_cnt += int'(stall);
      end
      chk("rmul no hilo_we", hw_cnt, 0);
      chk("rmul no stall", st_cnt, 0);
      dec("rmul add", 3'b010, 6'b100000, 4'b0010, 0, 2'b00, 0);

      // mult with instr_valid dropped mid-op, then mflo
      @(negedge clk); instr_valid = 1'b1; funct = 6'b011000; #1;
      chk("tmul c0 stall", 32'(stall), 1);
      hw_cyc = -1; st_cnt = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 2) instr_valid = 1'b0;
         if (c == 3) instr_valid = 1'b1;
         #1;
         if (hilo_we) begin
            chk("tmul done stall", 32'(stall), 0);
            hw_cyc = c;
            break;
         end
         st_cnt += int'(stall);
      end
      chk("tmul hilo cyc", hw_cyc, 5);
      chk("tmul stall cnt", st_cnt, 4);
      @(negedge clk); funct = 6'b010010; #1;
      chk("mflo hs", 32'(hilo_sel), 32'(2'b10));
      chk("mflo stall", 32'(stall), 0);
      chk("mflo alu", 32'(alu_ctrl), 32'hf);
      @(negedge clk); #1;
      chk("mflo next stall", 32'(stall), 0);
      chk("mflo next start", 32'(md_start), 0);
      @(negedge clk); instr_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
